// File: rtl/rs_pkg.sv
// rtl/rs_pkg.sv - shared RS(15,11) GF(16) constants and decoder stage states
package rs_pkg;
  localparam int GF_W    = 4;
  localparam int RS_N    = 15;
  localparam int RS_K    = 11;
  localparam int RS_NSYN = 4;

  // alpha^j for j = 1..4 under x^4+x+1
  localparam logic [GF_W-1:0] ALPHA_POW [1:4] = '{4'd2, 4'd4, 4'd8, 4'd3};

  typedef logic [0:0] rs_state_t;
  localparam rs_state_t ST_IDLE = 1'b0;
  localparam rs_state_t ST_ACC  = 1'b1;
endpackage

// File: rtl/full_GF_mult.sv
// rtl/full_GF_mult.sv - combinational GF(16) multiplier, polynomial x^4+x+1
module full_GF_mult (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] p
);
  logic [3:0] acc;
  logic [3:0] sh;

  // shift-and-add; each shift reduces by x^4 = x + 1
  always_comb begin
    acc = 4'd0;
    sh  = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[2:0], 1'b0} ^ {2'b00, sh[3], sh[3]};
    end
    p = acc;
  end
endmodule

// File: rtl/rs_syn_cell.sv
// rtl/rs_syn_cell.sv - one Horner cell accumulating r(alpha^j)
module rs_syn_cell
  import rs_pkg::*;
#(
  parameter logic [GF_W-1:0] ALPHA = 4'd2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  logic [GF_W-1:0] sym,
  output logic [GF_W-1:0] acc,
  output logic [GF_W-1:0] next
);
  logic [GF_W-1:0] prod;

  full_GF_mult u_mult (
    .a (acc),
    .b (ALPHA),
    .p (prod)
  );

  assign next = prod ^ sym;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (load) begin
      acc <= sym;
    end else if (step) begin
      acc <= next;
    end
  end
endmodule

// File: rtl/rs_syndrome_calc.sv
// rtl/rs_syndrome_calc.sv - RS(15,11) syndrome stage: serial symbols in, S1..S4 out
module rs_syndrome_calc
  import rs_pkg::*;
#(
  parameter int N_SYM = 15,
  parameter int N_SYN = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic       in_sop,
  input  logic [3:0] in_sym,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] syn1,
  output logic [3:0] syn2,
  output logic [3:0] syn3,
  output logic [3:0] syn4,
  output logic       syn_nonzero,
  output logic       sop_err
);
  localparam logic [3:0] LAST = 4'(N_SYM - 1);

  logic [3:0]      cnt;
  rs_state_t       state;
  logic [GF_W-1:0] nxt   [1:N_SYN];
  logic [GF_W-1:0] acc   [1:N_SYN];
  logic [GF_W-1:0] syn_q [1:N_SYN];
  logic            xfer, sop_xfer, step, final_xfer, drop, any_nz;

  // only the last symbol of a codeword must wait for a pending set
  assign in_ready   = ~(out_valid & ~out_ready & (cnt == LAST));
  assign xfer       = in_valid & in_ready;
  assign sop_xfer   = xfer & in_sop;
  assign step       = xfer & ~in_sop & (state == ST_ACC);
  assign final_xfer = step & (cnt == LAST);
  assign drop       = xfer & ~in_sop & (state == ST_IDLE);

  for (genvar j = 1; j <= N_SYN; j++) begin : g_cell
    rs_syn_cell #(.ALPHA(ALPHA_POW[j])) u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (sop_xfer),
      .step  (step),
      .sym   (in_sym),
      .acc   (acc[j]),
      .next  (nxt[j])
    );
  end

  always_comb begin
    any_nz = 1'b0;
    for (int j = 1; j <= N_SYN; j++) any_nz = any_nz | (|nxt[j]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt         <= '0;
      state       <= ST_IDLE;
      out_valid   <= 1'b0;
      syn_nonzero <= 1'b0;
      sop_err     <= 1'b0;
      for (int j = 1; j <= N_SYN; j++) syn_q[j] <= '0;
    end else begin
      sop_err <= drop;
      if (sop_xfer) begin
        cnt   <= 4'd1;
        state <= ST_ACC;
      end else if (final_xfer) begin
        cnt   <= '0;
        state <= ST_IDLE;
      end else if (step) begin
        cnt <= cnt + 4'd1;
      end
      if (final_xfer) begin
        out_valid   <= 1'b1;
        syn_nonzero <= any_nz;
        for (int j = 1; j <= N_SYN; j++) syn_q[j] <= nxt[j];
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign syn1 = syn_q[1];
  assign syn2 = syn_q[2];
  assign syn3 = syn_q[3];
  assign syn4 = syn_q[4];
endmodule

// File: tb/tb_rs_syndrome_calc.sv
// tb/tb_rs_syndrome_calc.sv - randomized self-checking bench for rs_syndrome_calc
module tb_rs_syndrome_calc;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_sop = 1'b0;
  logic [3:0] in_sym = 4'd0;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [3:0] syn1, syn2, syn3, syn4;
  logic       syn_nonzero;
  logic       sop_err;

  rs_syndrome_calc #(.N_SYM(15), .N_SYN(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_sop      (in_sop),
    .in_sym      (in_sym),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .syn1        (syn1),
    .syn2        (syn2),
    .syn3        (syn3),
    .syn4        (syn4),
    .syn_nonzero (syn_nonzero),
    .sop_err     (sop_err)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail = 0;
  int          ready_drops = 0;
  bit          rnd_ready = 1'b0;
  logic [15:0] exp_q [$];
  logic [3:0]  cw_model [$];
  bit          in_cw = 1'b0;
  logic [3:0]  cw_buf [15];
  logic [3:0]  gexp [15];
  int          glog [16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] b);
    if (a == 4'd0 || b == 4'd0) return 4'd0;
    return gexp[(glog[a] + glog[b]) % 15];
  endfunction

  // direct evaluation S_j = sum r_i * alpha^(i*j) over the collected codeword
  function automatic logic [15:0] ref_syn();
    logic [15:0] r;
    logic [3:0]  s;
    r = '0;
    for (int j = 1; j <= 4; j++) begin
      s = 4'd0;
      for (int k = 0; k < 15; k++) s = s ^ gmul(cw_model[k], gexp[((14 - k) * j) % 15]);
      r[(4 - j) * 4 +: 4] = s;
    end
    return r;
  endfunction

  task automatic model_step(input bit sop, input logic [3:0] sym, output bit drop, output bit done);
    drop = 1'b0;
    done = 1'b0;
    if (sop) begin
      cw_model.delete();
      cw_model.push_back(sym);
      in_cw = 1'b1;
    end else if (!in_cw) begin
      drop = 1'b1;
    end else begin
      cw_model.push_back(sym);
      if (cw_model.size() == 15) begin
        exp_q.push_back(ref_syn());
        in_cw = 1'b0;
        done  = 1'b1;
      end
    end
  endtask

  always @(negedge clk) begin
    logic [15:0] e;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_set", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("syn", {16'd0, syn1, syn2, syn3, syn4}, {16'd0, e});
        check("syn_nonzero", {31'd0, syn_nonzero}, {31'd0, |e});
      end
    end
  end

  task automatic drive(input bit v, input bit sop, input logic [3:0] sym, output bit xfer);
    bit drop, done;
    in_valid = v;
    in_sop   = sop;
    in_sym   = sym;
    if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
    @(negedge clk);
    xfer = v & in_ready;
    if (v && !in_ready) ready_drops++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (xfer) begin
      model_step(sop, sym, drop, done);
      check("sop_err", {31'd0, sop_err}, {31'd0, drop});
      if (done) check("out_valid_latency", {31'd0, out_valid}, 32'd1);
    end else begin
      check("sop_err_idle", {31'd0, sop_err}, 32'd0);
    end
  endtask

  task automatic push_sym(input bit sop, input logic [3:0] sym);
    bit x;
    x = 1'b0;
    for (int t = 0; t < 50 && !x; t++) drive(1'b1, sop, sym, x);
    if (!x) check("stall_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_buf();
    for (int k = 0; k < 15; k++) push_sym(k == 0, cw_buf[k]);
  endtask

  task automatic single_buf(input int k, input logic [3:0] v);
    for (int i = 0; i < 15; i++) cw_buf[i] = 4'd0;
    cw_buf[k] = v;
  endtask

  task automatic idle(input int n);
    bit x;
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 4'd0, x);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit x;
    gexp[0] = 4'd1;
    for (int i = 1; i < 15; i++)
      gexp[i] = {gexp[i-1][2:0], 1'b0} ^ {2'b00, gexp[i-1][3], gexp[i-1][3]};
    glog[0] = 0;
    for (int i = 0; i < 15; i++) glog[gexp[i]] = i;

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_syn", {16'd0, syn1, syn2, syn3, syn4}, 32'd0);
    check("rst_nonzero", {31'd0, syn_nonzero}, 32'd0);
    check("rst_sop_err", {31'd0, sop_err}, 32'd0);
    rst_n = 1'b1;

    // all-zero, r0 = 5, r14 = 1 (constant expectations alongside the model)
    single_buf(0, 4'd0);
    send_buf();
    idle(1);
    check("ov_one_cycle", {31'd0, out_valid}, 32'd0);
    single_buf(14, 4'd5);
    send_buf();
    #2;
    check("r0_5", {16'd0, syn1, syn2, syn3, syn4}, 32'h5555);
    idle(1);
    single_buf(0, 4'd1);
    send_buf();
    #2;
    check("r14_1", {16'd0, syn1, syn2, syn3, syn4}, 32'h9DFE);
    idle(1);

    // r1 = 1 then r14 = 1, back to back
    ready_drops = 0;
    single_buf(13, 4'd1);
    send_buf();
    #2;
    check("r1_1", {16'd0, syn1, syn2, syn3, syn4}, 32'h2483);
    single_buf(0, 4'd1);
    send_buf();
    #2;
    check("b2b_second", {16'd0, syn1, syn2, syn3, syn4}, 32'h9DFE);
    check("b2b_no_stall", ready_drops, 32'd0);
    idle(1);

    // stall: first set pending while second codeword reaches its last symbol
    out_ready = 1'b0;
    for (int k = 0; k < 15; k++) cw_buf[k] = 4'($urandom_range(0, 15));
    send_buf();
    for (int k = 0; k < 14; k++) push_sym(k == 0, 4'($urandom_range(0, 15)));
    in_valid = 1'b1;
    in_sop   = 1'b0;
    in_sym   = 4'd6;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      check("stall_syn_stable", {16'd0, syn1, syn2, syn3, syn4}, {16'd0, exp_q[0]});
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    drive(1'b1, 1'b0, 4'd6, x);
    check("stall_release", {31'd0, x}, 32'd1);
    idle(2);

    // stray symbol at IDLE, then a restarted codeword
    drive(1'b1, 1'b0, 4'd7, x);
    idle(1);
    check("drop_no_out", {31'd0, out_valid}, 32'd0);
    for (int k = 0; k < 6; k++) push_sym(k == 0, 4'($urandom_range(1, 15)));
    single_buf(0, 4'd1);
    send_buf();
    #2;
    check("restart_syn", {16'd0, syn1, syn2, syn3, syn4}, 32'h9DFE);
    idle(1);

    // reset mid-codeword with a set pending
    out_ready = 1'b0;
    for (int k = 0; k < 15; k++) cw_buf[k] = 4'($urandom_range(0, 15));
    send_buf();
    for (int k = 0; k < 5; k++) push_sym(k == 0, 4'($urandom_range(0, 15)));
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_syn", {16'd0, syn1, syn2, syn3, syn4}, 32'd0);
    check("mid_rst_nonzero", {31'd0, syn_nonzero}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    exp_q.delete();
    cw_model.delete();
    in_cw = 1'b0;
    out_ready = 1'b1;

    // randomized traffic with random back-pressure, gaps, strays and restarts
    rnd_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      idle($urandom_range(0, 2));
      if ($urandom_range(0, 7) == 0) drive(1'b1, 1'b0, 4'($urandom_range(0, 15)), x);
      if ($urandom_range(0, 7) == 0) begin
        int len;
        len = $urandom_range(1, 10);
        for (int k = 0; k < len; k++) push_sym(k == 0, 4'($urandom_range(0, 15)));
      end
      for (int k = 0; k < 15; k++)
        cw_buf[k] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      send_buf();
    end
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    idle(3);
    check("drain_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/rs_syndrome_calc.md
# rs_syndrome_calc

Syndrome-computation stage of the RS(15,11) decoder over GF(16), primitive polynomial x^4+x+1, α = 2. Accepts a received codeword as a serial stream of 15 4-bit symbols and evaluates the four syndromes S_j = r(α^j), j = 1..4, by Horner accumulation. Each multiplication uses the team's GF(16) multiplier. The stage sits between the input symbol interface and the key-equation solver, and hands the solver one syndrome set per codeword over a valid/ready handshake.

## Interface
Parameters:
- N_SYM, 15, symbols per codeword; only 15 is supported.
- N_SYN, 4, number of syndromes; only 4 is supported.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset; **synchronous, active-low**.
- in_valid  in  1  in_sym is valid this cycle.
- in_sop  in  1  marks the first symbol of a codeword, which is coefficient r14.
- in_sym  in  4  received symbol, highest-degree coefficient first.
- in_ready  out  1  stage can accept a symbol.
- out_valid  out  1  syn1..syn4 hold a completed syndrome set.
- out_ready  in  1  downstream consumes the set.
- syn1, syn2, syn3, syn4  out  4 each  S1..S4.
- syn_nonzero  out  1  OR of all syndrome bits; 1 means the codeword is corrupt.
- sop_err  out  1  one-cycle pulse: a symbol arrived at IDLE without in_sop; that symbol is dropped.

## Operation
- A transfer occurs when in_valid & in_ready.
- Counter cnt runs 0..14. It has two states:
  - IDLE: cnt = 0, waiting for in_sop.
  - ACC: cnt = 1..14.
- Transfer with in_sop, in any state:
  - acc_j <= in_sym for every j.
  - cnt <= 1 and state goes to ACC.
  - A partial codeword in progress is silently discarded.
- Transfer without in_sop in IDLE: the symbol is dropped, sop_err pulses, and state is unchanged.
- Transfer without in_sop in ACC: acc_j <= (acc_j ⊗ α^j) ⊕ in_sym, with α^1..α^4 = 2, 4, 8, 3.
- Final symbol (transfer with cnt = 14):
  - The output registers load the final accumulation: syn_j <= (acc_j ⊗ α^j) ⊕ in_sym.
  - out_valid <= 1 and state goes to IDLE.
  - The accumulators are not needed afterwards, so the next codeword can follow immediately.
- Output handshake:
  - out_valid stays 1 and syn* stay stable until out_ready.
  - out_ready with no new load in the same cycle clears out_valid.
  - Load and consume in the same cycle: out_valid stays 1 and the new set is presented.
- in_ready = ~(out_valid & ~out_ready & (cnt == 14)). This stalls only the final symbol of the next codeword while the previous set is still pending.
- Arithmetic: all additions are 4-bit XOR; no width growth.

## Timing
- Reset values: in_ready = 1, out_valid = 0, syn1..syn4 = 0, syn_nonzero = 0, sop_err = 0, cnt = 0, state IDLE, acc = 0.
- Latency: out_valid rises on the first edge after the 15th transfer.
- Throughput: one symbol per cycle, back-to-back codewords with no gap when out_ready = 1.
- in_ready is combinational from out_ready; there is no other combinational path from input to output.
- Reset asserted mid-codeword discards the partial codeword and any pending output set.
- sop_err is registered and is high for exactly one cycle per dropped symbol.

## Structure
- Shared package rs_pkg:
  - GF_W = 4, RS_N = 15, RS_K = 11, RS_NSYN = 4.
  - ALPHA_POW[1:4] = {2, 4, 8, 3}.
  - The state enumeration, shared with later decoder stages.
- Natural sub-module rs_syn_cell: one Horner cell holding acc_j, parameterised by its α^j constant. Each cell instantiates full_GF_mult with B tied to the constant, giving four instances in total.
- Counter, FSM and output registers live in the top level.

## Test plan
- All-zero codeword with out_ready = 1 -> syn = 0, 0, 0, 0; syn_nonzero = 0; out_valid for one cycle, 1 cycle after the last symbol.
- Zeros except the last symbol (r0) = 5 -> syn = 5, 5, 5, 5; syn_nonzero = 1.
- Only the first symbol (r14) = 1 -> syn = 9, 13, 15, 14.
- Only r1 = 1 (14th symbol), followed back-to-back by a second codeword with only r14 = 1 -> first set 2, 4, 8, 3; then 9, 13, 15, 14 exactly 15 cycles later; in_ready never drops.
- out_ready held 0 across a second full codeword -> in_ready drops while the 15th symbol is offered and the first set stays stable. Raising out_ready lets the 15th symbol transfer in that same cycle, and the new set appears on the next edge.
- Symbol without in_sop in IDLE -> sop_err pulses once and no output. New in_sop after 6 symbols -> the earlier partial is discarded and the syndromes match only the restarted codeword. rst_n = 0 mid-codeword -> out_valid = 0 and all outputs are 0 on the next edge.
